// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and byte-lane geometry of the 32-bit data word.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int HALF_W    = 16;
    localparam int DATA_W    = NUM_LANES * LANE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction/extension, sub-word store
// merge, and detection of misaligned or illegal accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic              i_is_store,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_word_in,
    input  logic [DATA_W-1:0] i_store_data,
    output logic [DATA_W-1:0] o_load_val,
    output logic [DATA_W-1:0] o_merged,
    output logic              o_err
);

    logic [LANE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    assign w_byte = i_word_in[{i_addr_lo, 3'b000} +: LANE_W];
    assign w_half = i_word_in[{i_addr_lo[1], 4'b0000} +: HALF_W];

    always_comb begin
        o_load_val = '0;
        case (i_funct3)
            F3_B:    o_load_val = {{(DATA_W-LANE_W){w_byte[LANE_W-1]}}, w_byte};
            F3_BU:   o_load_val = {{(DATA_W-LANE_W){1'b0}}, w_byte};
            F3_H:    o_load_val = {{(DATA_W-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_HU:   o_load_val = {{(DATA_W-HALF_W){1'b0}}, w_half};
            F3_W:    o_load_val = i_word_in;
            default: o_load_val = '0;
        endcase
    end

    // Sub-word stores overwrite only the addressed lane(s) of the current word.
    always_comb begin
        o_merged = i_word_in;
        case (i_funct3)
            F3_B:    o_merged[{i_addr_lo, 3'b000} +: LANE_W] = i_store_data[LANE_W-1:0];
            F3_H:    o_merged[{i_addr_lo[1], 4'b0000} +: HALF_W] = i_store_data[HALF_W-1:0];
            F3_W:    o_merged = i_store_data;
            default: o_merged = i_word_in;
        endcase
    end

    always_comb begin
        o_err = 1'b1;
        case (i_funct3)
            F3_B:    o_err = 1'b0;
            F3_H:    o_err = i_addr_lo[0];
            F3_W:    o_err = (i_addr_lo != 2'b00);
            F3_BU:   o_err = i_is_store;
            F3_HU:   o_err = i_is_store | i_addr_lo[0];
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-wide memory without byte enables;
// sub-word stores take a read-modify-write pass through the WRITE state.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int WORD_SIZE = 32,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 o_dbg_state
);

    // Handshake: a request transfers on a cycle where req_valid && req_ready;
    // the core holds its request stable until then. rsp_valid is a single-cycle
    // pulse per accepted request, with no backpressure on the response side.

    state_t                r_state;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [31:0]           r_rsp_rdata;
    logic [AW-1:0]         r_addr;
    logic [WORD_SIZE-1:0]  r_wdata;

    logic                  w_accept;
    logic                  w_err;
    logic                  w_full_store;
    logic [AW-1:0]         w_req_index;
    logic [WORD_SIZE-1:0]  w_load_val;
    logic [WORD_SIZE-1:0]  w_merged;
    logic                  w_unused_addr;

    assign w_req_index   = req_addr[AW+1:2];
    assign w_unused_addr = ^req_addr[31:AW+2];
    assign w_accept      = req_valid && (r_state == IDLE);
    assign w_full_store  = req_we && (req_funct3 == F3_W) && !w_err;

    lsu_align u_align (
        .i_funct3     (req_funct3),
        .i_is_store   (req_we),
        .i_addr_lo    (req_addr[1:0]),
        .i_word_in    (mem_rdata),
        .i_store_data (req_wdata),
        .o_load_val   (w_load_val),
        .o_merged     (w_merged),
        .o_err        (w_err)
    );

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign o_dbg_state = (r_state == WRITE);

    // Reset gates the write strobe directly so an in-flight RMW is never committed.
    assign mem_addr  = (r_state == WRITE) ? r_addr : w_req_index;
    assign mem_wdata = (r_state == WRITE) ? r_wdata : req_wdata;
    assign mem_we    = !rst && ((r_state == WRITE) || (w_accept && w_full_store));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (!req_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_load_val;
                        end else if (req_funct3 == F3_W) begin
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_addr  <= w_req_index;
                            r_wdata <= w_merged;
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit; the initiator side of the word-wide data memory.
- Translates RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. The memory has combinational read, synchronous full-word write, and no byte enables.
- Sub-word stores are done as read-modify-write over two cycles. The unit stalls the core while busy.
- Sits between the core's execute stage and the data memory.

Parameters:
- DEPTH, 1024, memory depth in 32-bit words; memory word index width is $clog2(DEPTH).
- WORD_SIZE, 32, data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core issues a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- req_ready  out  1  high when state is IDLE; a request is accepted iff req_valid && req_ready.
- rsp_valid  out  1  one-cycle pulse per completed request.
- rsp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned access or illegal funct3.
- mem_addr  out  $clog2(DEPTH)  word index = req_addr[$clog2(DEPTH)+1:2]; upper bits ignored (wrap).
- mem_we  out  1  memory write enable.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_rdata  in  WORD_SIZE  memory combinational read data.

Behaviour:
- Reset, synchronous: state = IDLE; rsp_valid, rsp_err = 0; rsp_rdata = 0; captured address and data registers = 0. mem_we is forced to 0 combinationally while rst = 1, so a write in flight is never committed during reset.
- States: IDLE and WRITE.
- IDLE, no request: mem_addr = word index of req_addr; mem_we = 0.
- IDLE, accepted request, illegal case: covers a misaligned access (H/HU/SH with addr[0] = 1; W/SW with addr[1:0] != 0) or an illegal funct3 (011/110/111 for loads; anything other than 000/001/010 for stores). No write. Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Load, accepted in IDLE:
  - Select the lane of mem_rdata by addr[1:0], extend it, and register it.
  - Next cycle: rsp_valid = 1, rsp_rdata = result. Latency 1 cycle.
- SW, accepted in IDLE: mem_we = 1 and mem_wdata = req_wdata in the same cycle. Next cycle: rsp_valid = 1. Latency 1 cycle.
- SB/SH, accepted in IDLE:
  - mem_we = 0 in the accept cycle.
  - Merge the req_wdata low byte/half into mem_rdata at lane addr[1:0]. Register the merged word and the word index.
  - Go to WRITE.
- WRITE state:
  - Drive mem_addr = captured index, mem_we = 1, mem_wdata = merged word. req_ready = 0.
  - Next cycle: state = IDLE and rsp_valid = 1. Latency 2 cycles; exactly one stall cycle.
- req_valid while req_ready = 0: ignored. The core holds the request; no queueing.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid pulses for the previous one (the state is IDLE then).
- Reset in WRITE: the write is dropped, no rsp_valid, and the unit is IDLE after the edge.
- Wrap-around: address bits above $clog2(DEPTH)+1 are ignored. No error for out-of-range addresses.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum state_t {IDLE, WRITE}.
  - Lane/width helper constants.
- Sub-module lsu_align, purely combinational:
  - Inputs: funct3, addr[1:0], word_in, store_data.
  - Outputs: extended load value, merged store word, misaligned/illegal flag.
- The top holds the FSM, registers, and memory-side muxing.

Test Plan:
Each scenario uses a RAM model with DEPTH = 1024 and mem[4] = 0x80FF7F01 (byte address 0x10).
- Loads on mem[4]:
  - LB 0x13 -> rsp_rdata 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80FF.
  - LHU 0x10 -> 0x00007F01.
  - LW 0x10 -> 0x80FF7F01.
  - Each response arrives 1 cycle after accept.
- SB 0x11, wdata 0x12345655 -> req_ready low for exactly 1 cycle; mem[4] = 0x80FF5501; rsp_valid 2 cycles after accept, rsp_err = 0.
- SH 0x11 -> rsp_err = 1 after 1 cycle, mem_we never asserted, mem[4] unchanged. LW 0x12 -> rsp_err = 1. Load with funct3 = 011 -> rsp_err = 1.
- SW 0x1000, wdata 0xDEADBEEF -> wraps to mem[0] = 0xDEADBEEF. Immediately follow with LW 0x0 accepted on the rsp cycle -> 0xDEADBEEF.
- SB 0x10 with rst asserted during the WRITE cycle -> mem[4] unchanged, no rsp_valid, req_ready = 1 after reset.
- req_valid held high during WRITE with a different request -> that request is not accepted until IDLE; exactly one rsp per accepted request.
